min2_stream_vg: RTL
===================

MIN2_STREAM_VG -- requirements
Module: min2_stream_vg

Interface
REQ-001 SHALL have parameter W, default 6: LLR word width; magnitude width is W-1.
REQ-002 SHALL have parameter P, default 8: magnitude lanes accepted per beat; power of two, 2..32.
REQ-003 SHALL have parameter NBEAT, default 4: beats per frame, >=1; row degree Wc = P*NBEAT.
REQ-004 SHALL have derived localparam IW = clog2(P*NBEAT): index width; 5 at defaults.
REQ-005 clk  input  1  the single clock; all logic on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  beat qualifier.
REQ-008 in_last  input  1  final beat of frame; meaningful only with in_valid.
REQ-009 in_mag  input  P*(W-1)  lane k at bits [k*(W-1) +: W-1], unsigned.
REQ-010 out_valid  output  1  one-cycle result strobe.
REQ-011 min1  output  W-1  smallest magnitude in frame.
REQ-012 min2  output  W-1  second smallest magnitude (duplicates counted).
REQ-013 idx  output  IW  global position of min1 = beat*P + lane.
REQ-014 out_err  output  1  frame length mismatch flag, valid with out_valid.

Function
REQ-015 Stage 1 SHALL reduce the P lanes of each accepted beat to (bmin1, bmin2, blane) via a pairwise tree, registered with a beat-valid, beat number and last flag.
REQ-016 Tree merge SHALL pick B over A only if B.min1 < A.min1 (strict); on ties the lower index wins and min2 takes the tied value.
REQ-017 Merged min2 SHALL be min(loser.min1, winner.min2).
REQ-018 Stage 2 FSM SHALL have states IDLE and ACC; the first beat of a frame loads the accumulator directly (no merge with stale data), later beats merge with the same rule, with the beat treated as the higher index.
REQ-019 A beat counter SHALL increment per accepted beat; frame closes on in_last or when the counter equals NBEAT-1, whichever comes first; the counter then returns to 0 and the FSM to IDLE.
REQ-020 out_err SHALL be 1 when the closing beat has in_last XOR (count==NBEAT-1) set, else 0.
REQ-021 out_valid SHALL pulse exactly 2 cycles after the closing beat's in_valid edge; min1/min2/idx/out_err are registered and held until the next pulse.
REQ-022 in_valid low SHALL freeze counter and accumulator; gaps of any length are allowed mid-frame.
REQ-023 Back-to-back frames with no idle cycle SHALL be supported at one beat per cycle, with no cross-frame contamination.
REQ-024 With NBEAT=1 every beat SHALL be a complete frame; out_err = ~in_last.

Reset
REQ-025 rst SHALL asynchronously clear out_valid, min1, min2, idx, out_err, counter, pipeline valids and the FSM (IDLE).
REQ-026 A frame partially accepted when rst asserts SHALL be discarded and produce no out_valid.
REQ-027 Stimulus accepted in the cycle rst deasserts SHALL be processed normally.

Configuration
REQ-028 Macro MIN2VG_SIGN_PARITY_EN defined: port in_sgn (input, P bits, one sign per lane) and port sgn_par (output, 1 bit) exist; sgn_par = XOR of all in_sgn bits of the frame, updated with out_valid, reset to 0.
REQ-029 Macro undefined: both ports and all sign logic are absent; other behaviour is identical.

Verification (P=8, NBEAT=4, W=6)
REQ-030 All lanes 31 except beat0 lane5=7 and beat2 lane3=4, in_last on beat3 -> out_valid 2 cycles later, min1=4, min2=7, idx=19, out_err=0.
REQ-031 beat0 lane0=2 and beat3 lane1=2, others 20 -> min1=2, min2=2, idx=0.
REQ-032 in_last on beat1 with beat1 lane7=1 -> out_valid, out_err=1, min1=1, idx=15; the next frame starts at beat 0.
REQ-033 rst pulse after 2 beats, then a full frame with min 9 at beat3 lane0 -> one out_valid only, min1=9, idx=24.
REQ-034 Two frames back to back, frame A min 3 at idx 6 and frame B all 30 -> pulses 4 cycles apart; second pulse min1=30, min2=30, idx=0.
REQ-035 With MIN2VG_SIGN_PARITY_EN, three sign bits set across the frame -> sgn_par=1; four set -> sgn_par=0.

Source files
------------

// File: rtl/min2_stream_vg.sv
// Streaming min1/min2/argmin finder over NBEAT beats of P magnitude lanes.
// Latency: out_valid pulses 2 cycles after the edge that accepts a frame's closing beat.
// Backpressure: none, one beat per cycle always; in_valid low simply stalls the frame.
// Optional sign parity output enabled by defining MIN2VG_SIGN_PARITY_EN.
module min2_stream_vg #(
  parameter  int W     = 6,
  parameter  int P     = 8,
  parameter  int NBEAT = 4,
  localparam int IW    = $clog2(P * NBEAT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [P*(W-1)-1:0]   in_mag,
`ifdef MIN2VG_SIGN_PARITY_EN
  input  logic [P-1:0]         in_sgn,
  output logic                 sgn_par,
`endif
  output logic                 out_valid,
  output logic [W-2:0]         min1,
  output logic [W-2:0]         min2,
  output logic [IW-1:0]        idx,
  output logic                 out_err
);

  localparam int MW = W - 1;
  localparam int BW = (NBEAT > 1) ? $clog2(NBEAT) : 1;

  // Candidate: smallest, second smallest and position of the smallest.
  typedef struct packed {
    logic [MW-1:0] m1;
    logic [MW-1:0] m2;
    logic [IW-1:0] ix;
  } cand_t;

  typedef enum logic {IDLE, ACC} state_t;

  // b only wins on a strictly smaller min1, so equal values keep the lower index.
  function automatic cand_t merge(input cand_t a, input cand_t b);
    cand_t w;
    cand_t l;
    cand_t r;
    if (b.m1 < a.m1) begin
      w = b;
      l = a;
    end else begin
      w = a;
      l = b;
    end
    r    = w;
    r.m2 = (l.m1 < w.m2) ? l.m1 : w.m2;
    return r;
  endfunction

  // Heap-ordered pairwise tree: leaves at P..2P-1, root at 1; left child holds lower lanes.
  function automatic cand_t tree_reduce(input logic [P*MW-1:0] mag);
    cand_t node [1:2*P-1];
    for (int k = 0; k < P; k++) begin
      node[P+k].m1 = mag[k*MW +: MW];
      node[P+k].m2 = '1;
      node[P+k].ix = IW'(k);
    end
    for (int i = P - 1; i >= 1; i--) begin
      node[i] = merge(node[2*i], node[2*i+1]);
    end
    return node[1];
  endfunction

  cand_t           beat_c;
  logic [BW-1:0]   beat_cnt;
  logic            in_close;

  logic            s1_vld;
  logic            s1_last;
  logic [BW-1:0]   s1_beat;
  cand_t           s1_cand;
  cand_t           s1_glob;
  logic            s1_end;
  logic            s1_close;
  logic            s1_err;

  state_t          state_q;
  state_t          state_d;
  cand_t           acc_q;
  cand_t           acc_d;
  logic            fin_vld_q;
  logic            fin_vld_d;
  logic            fin_err_q;
  logic            fin_err_d;

`ifdef MIN2VG_SIGN_PARITY_EN
  logic            s1_par;
  logic            acc_par_q;
  logic            acc_par_d;
`endif

  assign beat_c   = tree_reduce(in_mag);
  assign in_close = in_last | (beat_cnt == BW'(NBEAT - 1));

  // Beat counter: advances per accepted beat, rewinds when the frame closes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (in_valid) begin
      beat_cnt <= in_close ? '0 : beat_cnt + BW'(1);
    end
  end

  // Stage 1: register the per-beat reduction with its beat number and last flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_beat <= '0;
      s1_cand <= '0;
    end else begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_last <= in_last;
        s1_beat <= beat_cnt;
        s1_cand <= beat_c;
      end
    end
  end

`ifdef MIN2VG_SIGN_PARITY_EN
  // Stage 1 sign parity of the accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_par <= 1'b0;
    end else if (in_valid) begin
      s1_par <= ^in_sgn;
    end
  end
`endif

  // Convert the lane index to a frame position and decide whether this beat closes the frame.
  always_comb begin
    s1_glob    = s1_cand;
    s1_glob.ix = IW'(int'(s1_beat) * P) + s1_cand.ix;
    s1_end     = (s1_beat == BW'(NBEAT - 1));
    s1_close   = s1_last | s1_end;
    s1_err     = s1_last ^ s1_end;
  end

  // Stage 2 FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage 2 next state: any accepted beat either closes the frame or leaves it open.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (s1_vld) state_d = s1_close ? IDLE : ACC;
      ACC:  if (s1_vld) state_d = s1_close ? IDLE : ACC;
    endcase
  end

  // Stage 2 outputs: first beat loads the accumulator, later beats merge as the higher index.
  always_comb begin
    acc_d     = acc_q;
    fin_vld_d = 1'b0;
    fin_err_d = 1'b0;
`ifdef MIN2VG_SIGN_PARITY_EN
    acc_par_d = acc_par_q;
`endif
    if (s1_vld) begin
      acc_d     = (state_q == IDLE) ? s1_glob : merge(acc_q, s1_glob);
      fin_vld_d = s1_close;
      fin_err_d = s1_err;
`ifdef MIN2VG_SIGN_PARITY_EN
      acc_par_d = (state_q == IDLE) ? s1_par : (acc_par_q ^ s1_par);
`endif
    end
  end

  // Stage 2 accumulator and frame-complete registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      fin_vld_q <= 1'b0;
      fin_err_q <= 1'b0;
`ifdef MIN2VG_SIGN_PARITY_EN
      acc_par_q <= 1'b0;
`endif
    end else begin
      acc_q     <= acc_d;
      fin_vld_q <= fin_vld_d;
      fin_err_q <= fin_err_d;
`ifdef MIN2VG_SIGN_PARITY_EN
      acc_par_q <= acc_par_d;
`endif
    end
  end

  // Result registers: strobe for one cycle, hold values until the next frame completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      min1      <= '0;
      min2      <= '0;
      idx       <= '0;
      out_err   <= 1'b0;
`ifdef MIN2VG_SIGN_PARITY_EN
      sgn_par   <= 1'b0;
`endif
    end else begin
      out_valid <= fin_vld_q;
      if (fin_vld_q) begin
        min1    <= acc_q.m1;
        min2    <= acc_q.m2;
        idx     <= acc_q.ix;
        out_err <= fin_err_q;
`ifdef MIN2VG_SIGN_PARITY_EN
        sgn_par <= acc_par_q;
`endif
      end
    end
  end

endmodule
